// File: rtl/life_pkg.sv
// Shared types and rule constants for the Game-of-Life engine.
package life_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEED = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } state_t;

  // Fibonacci taps 32, 22, 2, 1 as a bit mask over lfsr[31:0]
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  localparam logic [3:0] BIRTH      = 4'd3;
  localparam logic [3:0] SURVIVE_LO = 4'd2;
  localparam logic [3:0] SURVIVE_HI = 4'd3;

  function automatic logic cell_rule(input logic alive, input logic [3:0] count);
    return alive ? (count == SURVIVE_LO || count == SURVIVE_HI) : (count == BIRTH);
  endfunction

endpackage

// File: rtl/life_next_gen.sv
// Combinational B3/S23 successor of a ROWS x COLS grid, toroidal or dead-bounded.
module life_next_gen
  import life_pkg::*;
#(
  parameter int unsigned ROWS = 8,
  parameter int unsigned COLS = 8,
  parameter int unsigned WRAP = 1
) (
  input  logic [ROWS*COLS-1:0] grid,
  output logic [ROWS*COLS-1:0] next_grid
);

  localparam int unsigned N  = ROWS * COLS;
  localparam int unsigned IW = $clog2(N);

  function automatic logic [3:0] count_at(input logic [N-1:0] g,
                                          input int unsigned r,
                                          input int unsigned c);
    logic [3:0]  n;
    int unsigned rr;
    int unsigned cc;
    n = '0;
    for (int unsigned dr = 0; dr < 3; dr++) begin
      for (int unsigned dc = 0; dc < 3; dc++) begin
        // indices are biased by ROWS/COLS so the -1 offset stays unsigned
        rr = r + dr + ROWS - 1;
        cc = c + dc + COLS - 1;
        if (!(dr == 1 && dc == 1)) begin
          if (WRAP != 0)
            n = n + 4'(g[IW'((rr % ROWS) * COLS + (cc % COLS))]);
          else if (rr >= ROWS && rr < 2 * ROWS && cc >= COLS && cc < 2 * COLS)
            n = n + 4'(g[IW'((rr - ROWS) * COLS + (cc - COLS))]);
        end
      end
    end
    return n;
  endfunction

  always_comb begin
    next_grid = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        next_grid[IW'(r * COLS + c)] = cell_rule(grid[IW'(r * COLS + c)], count_at(grid, r, c));
      end
    end
  end

endmodule

// File: rtl/life_engine.sv
// Game-of-Life engine: grid register, run/step/seed control, LFSR seeding,
// generation counter and still-life / extinction flags.
module life_engine
  import life_pkg::*;
#(
  parameter int unsigned ROWS      = 8,
  parameter int unsigned COLS      = 8,
  parameter int unsigned WRAP      = 1,
  parameter int unsigned GEN_DIV   = 1,
  parameter int unsigned AUTO_HALT = 1,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 step,
  input  logic                 randomize,
  output logic [ROWS*COLS-1:0] grid,
  output logic [15:0]          gen_count,
  output logic                 stable,
  output logic                 extinct,
  output logic [1:0]           state_o
);

  localparam int unsigned N  = ROWS * COLS;
  localparam int unsigned IW = $clog2(N);
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned DW = (GEN_DIV > 1) ? $clog2(GEN_DIV) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [DW-1:0] LAST_DIV = DW'(GEN_DIV - 1);

  function automatic logic [N-1:0] blinker();
    logic [N-1:0] b;
    b = '0;
    for (int unsigned i = 0; i < 3; i++) b[IW'((ROWS / 2) * COLS + COLS / 2 - 1 + i)] = 1'b1;
    return b;
  endfunction

  localparam logic [N-1:0] BLINKER = blinker();

  state_t        state;
  state_t        state_next;
  logic [31:0]   lfsr;
  logic [DW-1:0] div;
  logic [DW-1:0] div_next;
  logic [RW-1:0] row_idx;
  logic [N-1:0]  next_grid;
  logic          settled;
  logic          commit;
  logic          seed_wr;
  logic          enter_seed;

  life_next_gen #(
    .ROWS(ROWS),
    .COLS(COLS),
    .WRAP(WRAP)
  ) u_next_gen (
    .grid     (grid),
    .next_grid(next_grid)
  );

  always_comb begin
    settled = (next_grid == grid) || (next_grid == '0);
    state_o = state;
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    div_next   = '0;
    commit     = 1'b0;
    seed_wr    = 1'b0;
    enter_seed = 1'b0;
    unique case (state)
      IDLE, HALT: begin
        if (randomize) begin
          state_next = SEED;
          enter_seed = 1'b1;
        end else if (!stop) begin
          if (start)     state_next = RUN;
          else if (step) commit     = 1'b1;
        end
      end
      SEED: begin
        seed_wr = 1'b1;
        if (row_idx == LAST_ROW) state_next = HALT;
      end
      RUN: begin
        if (stop) begin
          state_next = HALT;
        end else if (div == LAST_DIV) begin
          commit = 1'b1;
          if (AUTO_HALT != 0 && settled) state_next = HALT;
        end else begin
          div_next = div + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      grid      <= BLINKER;
      gen_count <= '0;
      stable    <= 1'b0;
      extinct   <= 1'b0;
      lfsr      <= LFSR_SEED;
      div       <= '0;
      row_idx   <= '0;
    end else begin
      lfsr    <= {lfsr[30:0], ^(lfsr & LFSR_TAPS)};
      div     <= div_next;
      // an empty grid is its own successor; report it only as extinct
      stable  <= (next_grid == grid) && (grid != '0);
      extinct <= (grid == '0);
      if (enter_seed) begin
        gen_count <= '0;
        row_idx   <= '0;
      end
      if (seed_wr) begin
        grid[IW'(row_idx) * IW'(COLS) +: COLS] <= lfsr[COLS-1:0];
        row_idx <= (row_idx == LAST_ROW) ? '0 : row_idx + 1'b1;
      end
      if (commit) begin
        grid <= next_grid;
        if (gen_count != '1) gen_count <= gen_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_life_engine.sv
// Self-checking bench for life_engine: directed patterns plus LFSR-seeded runs
// compared against a cell-by-cell reference model of the B3/S23 rule.
module tb_life_engine;
  import life_pkg::*;

  localparam logic [63:0] BLINK_H = 64'h0000_0038_0000_0000;
  localparam logic [63:0] BLINK_V = 64'h0000_1010_1000_0000;
  localparam logic [63:0] GLIDER  = 64'h0000_0000_0007_0402;
  localparam logic [63:0] BLOCK   = 64'h0000_0000_0000_0303;
  localparam logic [63:0] SINGLE  = 64'h0000_0000_0800_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_a = 0, stop_a = 0, step_a = 0, rand_a = 0;
  logic        start_b = 0, stop_b = 0, step_b = 0, rand_b = 0;
  logic        start_c = 0, stop_c = 0, step_c = 0, rand_c = 0;
  logic [63:0] grid_a, grid_b, grid_c;
  logic [15:0] gen_a, gen_b, gen_c;
  logic        stable_a, stable_b, stable_c;
  logic        extinct_a, extinct_b, extinct_c;
  logic [1:0]  state_a, state_b, state_c;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] pat;
  logic [31:0] m_lfsr;

  always #5 clk = ~clk;

  always @(posedge clk)
    m_lfsr <= !reset ? 32'hACE1_2468
                     : {m_lfsr[30:0], m_lfsr[31] ^ m_lfsr[21] ^ m_lfsr[1] ^ m_lfsr[0]};

  life_engine #(.ROWS(8), .COLS(8), .WRAP(1), .GEN_DIV(1), .AUTO_HALT(1)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .stop(stop_a), .step(step_a),
    .randomize(rand_a), .grid(grid_a), .gen_count(gen_a), .stable(stable_a),
    .extinct(extinct_a), .state_o(state_a));

  life_engine #(.ROWS(8), .COLS(8), .WRAP(0), .GEN_DIV(1), .AUTO_HALT(1)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .stop(stop_b), .step(step_b),
    .randomize(rand_b), .grid(grid_b), .gen_count(gen_b), .stable(stable_b),
    .extinct(extinct_b), .state_o(state_b));

  life_engine #(.ROWS(8), .COLS(8), .WRAP(1), .GEN_DIV(4), .AUTO_HALT(1)) u_c (
    .clk(clk), .reset(reset), .start(start_c), .stop(stop_c), .step(step_c),
    .randomize(rand_c), .grid(grid_c), .gen_count(gen_c), .stable(stable_c),
    .extinct(extinct_c), .state_o(state_c));

  // Reference: each cell looks at its eight neighbours on an 8x8 board.
  function automatic logic [63:0] life(input logic [63:0] g, input bit wrap);
    logic [63:0] res;
    int n, rr, cc;
    res = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr == 0 && dc == 0) continue;
            rr = r + dr;
            cc = c + dc;
            if (wrap) begin
              rr = (rr + 8) % 8;
              cc = (cc + 8) % 8;
            end else if (rr < 0 || rr > 7 || cc < 0 || cc > 7) begin
              continue;
            end
            n += int'(g[6'(rr * 8 + cc)]);
          end
        end
        res[6'(r * 8 + c)] = (n == 3) || (g[6'(r * 8 + c)] && n == 2);
      end
    end
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_a(input logic [63:0] p);
    pat = p;
    force u_a.next_grid = pat;
    step_a = 1'b1;
    tick();
    step_a = 1'b0;
    release u_a.next_grid;
  endtask

  task automatic load_b(input logic [63:0] p);
    pat = p;
    force u_b.next_grid = pat;
    step_b = 1'b1;
    tick();
    step_b = 1'b0;
    release u_b.next_grid;
  endtask

  initial begin
    logic [63:0] g, nx, seeded;
    logic [15:0] gen;
    bit          mrun;
    logic        exp_st, exp_ex;

    @(negedge clk);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check("reset_grid", grid_a, BLINK_H);
    check("reset_gen", 64'(gen_a), 64'd0);
    check("reset_stable", 64'(stable_a), 64'd0);
    check("reset_extinct", 64'(extinct_a), 64'd0);
    check("reset_state", 64'(state_a), 64'(IDLE));

    // Single steps of the blinker
    step_a = 1'b1; tick(); step_a = 1'b0;
    check("step1_grid", grid_a, BLINK_V);
    check("step1_model", grid_a, life(BLINK_H, 1'b1));
    check("step1_gen", 64'(gen_a), 64'd1);
    step_a = 1'b1; tick(); step_a = 1'b0;
    check("step2_grid", grid_a, BLINK_H);
    check("step2_gen", 64'(gen_a), 64'd2);
    tick();
    check("step2_stable", 64'(stable_a), 64'd0);
    check("step2_state", 64'(state_a), 64'(IDLE));

    // Glider on the torus returns home after 32 generations
    load_a(GLIDER);
    check("glider_load", grid_a, GLIDER);
    g = GLIDER;
    gen = 16'd3;
    start_a = 1'b1;
    tick();
    check("glider_run", 64'(state_a), 64'(RUN));
    for (int i = 0; i < 32; i++) begin
      tick();
      g = life(g, 1'b1);
      gen++;
      check("glider_grid", grid_a, g);
      check("glider_extinct", 64'(extinct_a), 64'd0);
    end
    check("glider_home", grid_a, GLIDER);
    check("glider_gen", 64'(gen_a), 64'(gen));
    start_a = 1'b0; stop_a = 1'b1; tick(); stop_a = 1'b0;
    check("glider_stop", 64'(state_a), 64'(HALT));
    check("glider_stop_grid", grid_a, GLIDER);

    // Dead-boundary block: one commit then auto-halt as a still life
    load_b(BLOCK);
    start_b = 1'b1;
    tick();
    check("block_run", 64'(state_b), 64'(RUN));
    tick();
    start_b = 1'b0;
    check("block_halt", 64'(state_b), 64'(HALT));
    check("block_grid", grid_b, BLOCK);
    check("block_gen", 64'(gen_b), 64'd2);
    tick();
    check("block_stable", 64'(stable_b), 64'd1);
    check("block_extinct", 64'(extinct_b), 64'd0);

    // Lone cell dies: auto-halt on extinction
    load_b(SINGLE);
    start_b = 1'b1;
    tick();
    tick();
    start_b = 1'b0;
    check("single_grid", grid_b, 64'd0);
    check("single_halt", 64'(state_b), 64'(HALT));
    check("single_gen", 64'(gen_b), 64'd4);
    tick();
    check("single_extinct", 64'(extinct_b), 64'd1);
    check("single_stable", 64'(stable_b), 64'd0);

    // Divider of 4: commit on every fourth clock, stop mid-period
    start_c = 1'b1;
    tick();
    check("div_run", 64'(state_c), 64'(RUN));
    g = BLINK_H;
    gen = 16'd0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k % 4 == 0) begin
        g = life(g, 1'b1);
        gen++;
      end
      check("div_grid", grid_c, g);
      check("div_gen", 64'(gen_c), 64'(gen));
    end
    tick();
    stop_c = 1'b1;
    tick();
    check("div_stop_state", 64'(state_c), 64'(HALT));
    check("div_stop_gen", 64'(gen_c), 64'd2);
    check("div_stop_grid", grid_c, g);
    start_c = 1'b0; stop_c = 1'b0;
    repeat (3) tick();
    check("div_hold_state", 64'(state_c), 64'(HALT));
    check("div_hold_gen", 64'(gen_c), 64'd2);

    // LFSR seeding followed by a free run against the reference model
    for (int round = 0; round < 3; round++) begin
      repeat ($urandom_range(0, 9)) tick();
      rand_a = 1'b1;
      tick();
      rand_a = 1'b0;
      check("seed_state", 64'(state_a), 64'(SEED));
      check("seed_gen", 64'(gen_a), 64'd0);
      seeded = '0;
      for (int k = 0; k < 8; k++) begin
        seeded[k * 8 +: 8] = m_lfsr[7:0];
        check("seed_busy", 64'(state_a), 64'(SEED));
        tick();
      end
      check("seed_grid", grid_a, seeded);
      check("seed_done", 64'(state_a), 64'(HALT));
      g = seeded;
      gen = 16'd0;
      mrun = 1'b0;
      start_a = 1'b1;
      for (int t = 0; t < 24; t++) begin
        exp_ex = (g == '0);
        exp_st = (life(g, 1'b1) == g) && !exp_ex;
        if (!mrun) begin
          mrun = 1'b1;
        end else begin
          nx = life(g, 1'b1);
          if (nx == g || nx == '0) mrun = 1'b0;
          g = nx;
          if (gen != 16'hFFFF) gen++;
        end
        tick();
        check("rand_grid", grid_a, g);
        check("rand_gen", 64'(gen_a), 64'(gen));
        check("rand_state", 64'(state_a), mrun ? 64'(RUN) : 64'(HALT));
        check("rand_stable", 64'(stable_a), 64'(exp_st));
        check("rand_extinct", 64'(extinct_a), 64'(exp_ex));
      end
      start_a = 1'b0; stop_a = 1'b1; tick(); stop_a = 1'b0;
      check("rand_stop", 64'(state_a), 64'(HALT));
    end

    // Reset in the middle of seeding aborts it
    rand_a = 1'b1;
    tick();
    rand_a = 1'b0;
    repeat (3) tick();
    check("abort_seed", 64'(state_a), 64'(SEED));
    reset = 1'b0;
    tick();
    check("abort_grid", grid_a, BLINK_H);
    check("abort_state", 64'(state_a), 64'(IDLE));
    check("abort_gen", 64'(gen_a), 64'd0);
    check("abort_stable", 64'(stable_a), 64'd0);
    check("abort_extinct", 64'(extinct_a), 64'd0);
    reset = 1'b1;
    tick();
    check("abort_idle", 64'(state_a), 64'(IDLE));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
